// File: rtl/pad_attr_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pad_attr_ctrl: round-robin arbiter that legalizes and commits pad attributes.
// Revision: 1.0
// ----------------------------------------------------------------------------
module pad_attr_ctrl #(
  parameter int                NumPads      = 8,
  parameter int                NumReq       = 2,
  parameter int                AttrDw       = 13,
  parameter logic [AttrDw-1:0] AttrMask     = {AttrDw{1'b1}},
  parameter int                SettleCycles = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NumReq-1:0]                  req_i,
  input  logic [NumReq*$clog2(NumPads)-1:0]  pad_idx_i,
  input  logic [NumReq*AttrDw-1:0]           attr_i,
  output logic [NumReq-1:0]                  gnt_o,
  output logic [NumReq-1:0]                  err_o,
  output logic [NumPads*AttrDw-1:0]          attr_o,
  output logic [NumPads-1:0]                 attr_we_o,
  output logic                               busy_o
);

  localparam int IdxW = $clog2(NumPads);
  localparam int PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int CntW = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;

  localparam logic [IdxW:0]     c_NumPads    = (IdxW+1)'(NumPads);
  localparam logic [PtrW-1:0]   c_LastReq    = PtrW'(NumReq - 1);
  localparam logic [CntW-1:0]   c_SettleLoad = CntW'(SettleCycles - 1);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StCommit = 2'd1,
    StSettle = 2'd2
  } state_e;

  state_e                     state_q;
  logic [PtrW-1:0]            ptr_q;
  logic [CntW-1:0]            cnt_q;
  logic [AttrDw-1:0]          hold_attr_q;
  logic [NumPads-1:0]         we_q;
  logic [NumPads*AttrDw-1:0]  attr_q;

  logic                       win_valid;
  logic [PtrW-1:0]            win_idx;
  logic [PtrW-1:0]            cand;
  logic [IdxW-1:0]            win_pad;
  logic [AttrDw-1:0]          win_attr;
  logic                       win_in_range;
  logic                       grant;
  logic [PtrW-1:0]            ptr_d;
  logic [NumPads-1:0]         we_d;

  // Round-robin search starting at the pointer; first active request wins.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NumReq; k++) begin
      cand = PtrW'((int'(ptr_q) + k) % NumReq);
      if (!win_valid && req_i[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    win_pad      = pad_idx_i[int'(win_idx)*IdxW +: IdxW];
    win_attr     = attr_i[int'(win_idx)*AttrDw +: AttrDw];
    win_in_range = ({1'b0, win_pad} < c_NumPads);
    grant        = (state_q == StIdle) && win_valid;
    ptr_d        = (win_idx == c_LastReq) ? '0 : win_idx + PtrW'(1);
    gnt_o        = '0;
    err_o        = '0;
    if (grant) begin
      gnt_o[win_idx] = 1'b1;
      err_o[win_idx] = !win_in_range;
    end
    for (int p = 0; p < NumPads; p++) begin
      we_d[p] = grant && win_in_range && (win_pad == IdxW'(p));
    end
  end

  // The strobe is decoded during the grant so it is a clean register in COMMIT.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      cnt_q       <= '0;
      hold_attr_q <= '0;
      we_q        <= '0;
      attr_q      <= '0;
    end else begin
      we_q <= we_d;
      case (state_q)
        StIdle: begin
          if (grant) begin
            hold_attr_q <= win_attr;
            ptr_q       <= ptr_d;
            state_q     <= StCommit;
          end
        end
        StCommit: begin
          for (int p = 0; p < NumPads; p++) begin
            if (we_q[p]) begin
              attr_q[p*AttrDw +: AttrDw] <= hold_attr_q & AttrMask;
            end
          end
          cnt_q   <= c_SettleLoad;
          state_q <= StSettle;
        end
        StSettle: begin
          if (cnt_q == '0) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign attr_o    = attr_q;
  assign attr_we_o = we_q;
  assign busy_o    = (state_q != StIdle);

endmodule
`default_nettype wire

// File: tb/tb_pad_attr_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pad_attr_ctrl: directed self-checking bench for pad_attr_ctrl.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_pad_attr_ctrl;

  localparam int NP = 6;
  localparam int NR = 2;
  localparam int AW = 13;
  localparam int IW = 3;

  logic              clk_i;
  logic              rst_ni;
  logic [NR-1:0]     req_i;
  logic [NR*IW-1:0]  pad_idx_i;
  logic [NR*AW-1:0]  attr_i;
  logic [NR-1:0]     gnt_o;
  logic [NR-1:0]     err_o;
  logic [NP*AW-1:0]  attr_o;
  logic [NP-1:0]     attr_we_o;
  logic              busy_o;

  int checks   = 0;
  int failures = 0;

  logic [NP*AW-1:0]  exp_attr;

  pad_attr_ctrl #(
    .NumPads     (NP),
    .NumReq      (NR),
    .AttrDw      (AW),
    .AttrMask    (13'h0FFF),
    .SettleCycles(4)
  ) u_dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (req_i),
    .pad_idx_i(pad_idx_i),
    .attr_i   (attr_i),
    .gnt_o    (gnt_o),
    .err_o    (err_o),
    .attr_o   (attr_o),
    .attr_we_o(attr_we_o),
    .busy_o   (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic set_req(input int r, input logic [IW-1:0] pad, input logic [AW-1:0] attr);
    pad_idx_i[r*IW +: IW] = pad;
    attr_i[r*AW +: AW]    = attr;
  endtask

  // Drives one request on the grant cycle's negedge and walks through COMMIT and SETTLE.
  task automatic run_txn(input string tag, input logic [NR-1:0] req,
                         input logic [NR-1:0] exp_gnt, input logic [NR-1:0] exp_err,
                         input logic [NP-1:0] exp_we);
    @(negedge clk_i);
    req_i = req;
    #1;
    check_eq({tag, "_gnt"}, gnt_o, exp_gnt);
    check_eq({tag, "_err"}, err_o, exp_err);
    @(negedge clk_i);
    req_i = '0;
    #1;
    check_eq({tag, "_we"}, attr_we_o, exp_we);
    check_eq({tag, "_busy_commit"}, busy_o, 1'b1);
    repeat (4) @(negedge clk_i);
    check_eq({tag, "_busy_settle"}, busy_o, 1'b1);
    @(negedge clk_i);
    check_eq({tag, "_busy_idle"}, busy_o, 1'b0);
  endtask

  initial begin
    rst_ni    = 1'b0;
    req_i     = '0;
    pad_idx_i = '0;
    attr_i    = '0;
    exp_attr  = '0;

    repeat (3) @(negedge clk_i);
    check_eq("rst_attr", attr_o, '0);
    check_eq("rst_busy", busy_o, 1'b0);
    check_eq("rst_gnt", gnt_o, '0);
    check_eq("rst_we", attr_we_o, '0);
    rst_ni = 1'b1;

    // Single write with masking: 0x1ABC & 0x0FFF on pad 3.
    set_req(0, 3'd3, 13'h1ABC);
    @(negedge clk_i);
    req_i = 2'b01;
    #1;
    check_eq("t1_gnt", gnt_o, 2'b01);
    check_eq("t1_err", err_o, 2'b00);
    check_eq("t1_busy0", busy_o, 1'b0);
    @(negedge clk_i);
    req_i = '0;
    #1;
    check_eq("t1_we", attr_we_o, 6'b001000);
    check_eq("t1_attr_pre", attr_o[3*AW +: AW], 13'h0000);
    @(negedge clk_i);
    check_eq("t1_attr3", attr_o[3*AW +: AW], 13'h0ABC);
    check_eq("t1_we_off", attr_we_o, '0);
    repeat (3) @(negedge clk_i);
    check_eq("t1_busy_t5", busy_o, 1'b1);
    @(negedge clk_i);
    check_eq("t1_busy_t6", busy_o, 1'b0);

    // Round-robin under continuous requests after a fresh reset.
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    set_req(0, 3'd1, 13'h0011);
    set_req(1, 3'd4, 13'h0022);
    for (int c = 0; c < 24; c++) begin
      @(negedge clk_i);
      if (c == 0) req_i = 2'b11;
      #1;
      if (c % 6 == 0) check_eq("rr_gnt", gnt_o, ((c / 6) % 2 == 1) ? 2'b10 : 2'b01);
      else            check_eq("rr_gnt_gap", gnt_o, 2'b00);
    end
    @(negedge clk_i);
    req_i = '0;
    exp_attr = '0;
    exp_attr[1*AW +: AW] = 13'h0011;
    exp_attr[4*AW +: AW] = 13'h0022;
    check_eq("rr_attr", attr_o, exp_attr);

    // Out-of-range pad on requester 1 (pointer is back at 0, only req1 active).
    set_req(1, 3'd7, 13'h1FFF);
    run_txn("err", 2'b10, 2'b10, 2'b10, 6'b000000);
    check_eq("err_attr", attr_o, exp_attr);

    // Same pad written twice; last commit wins.
    set_req(0, 3'd2, 13'h0005);
    run_txn("wa", 2'b01, 2'b01, 2'b00, 6'b000100);
    exp_attr[2*AW +: AW] = 13'h0005;
    check_eq("wa_attr", attr_o, exp_attr);
    set_req(1, 3'd2, 13'h000A);
    run_txn("wb", 2'b10, 2'b10, 2'b00, 6'b000100);
    exp_attr[2*AW +: AW] = 13'h000A;
    check_eq("wb_attr", attr_o, exp_attr);
    check_eq("wb_attr0", attr_o[0*AW +: AW], 13'h0000);

    // Reset asserted while the write is in COMMIT.
    set_req(0, 3'd5, 13'h0123);
    @(negedge clk_i);
    req_i = 2'b01;
    #1;
    check_eq("rc_gnt", gnt_o, 2'b01);
    @(negedge clk_i);
    req_i = '0;
    #1;
    check_eq("rc_we", attr_we_o, 6'b100000);
    rst_ni = 1'b0;
    #1;
    check_eq("rc_attr", attr_o, '0);
    check_eq("rc_we_clr", attr_we_o, '0);
    check_eq("rc_busy", busy_o, 1'b0);
    @(negedge clk_i);
    check_eq("rc_attr_hold", attr_o, '0);
    set_req(1, 3'd0, 13'h00AA);
    rst_ni = 1'b1;
    req_i  = 2'b10;
    #1;
    check_eq("rc_first_gnt", gnt_o, 2'b10);

    // Request pulse during SETTLE must be ignored.
    @(negedge clk_i);
    req_i = '0;
    #1;
    check_eq("ps_we", attr_we_o, 6'b000001);
    @(negedge clk_i);
    exp_attr = '0;
    exp_attr[0*AW +: AW] = 13'h00AA;
    check_eq("ps_attr", attr_o, exp_attr);
    @(negedge clk_i);
    req_i = 2'b01;
    #1;
    check_eq("ps_gnt_settle", gnt_o, 2'b00);
    @(negedge clk_i);
    req_i = '0;
    #1;
    check_eq("ps_gnt_settle2", gnt_o, 2'b00);
    repeat (2) @(negedge clk_i);
    #1;
    check_eq("ps_busy_idle", busy_o, 1'b0);
    check_eq("ps_gnt_idle", gnt_o, 2'b00);
    @(negedge clk_i);
    #1;
    check_eq("ps_no_commit", busy_o, 1'b0);
    check_eq("ps_attr_final", attr_o, exp_attr);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
